// File: rtl/cache_types_pkg.sv
// Shared types and helpers for the L1-to-L2 request path.
package cache_types_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RECOVER} arb_state_t;
    typedef enum logic {CLIENT_I, CLIENT_D} client_t;

    localparam int unsigned LINE_OFFSET_BITS = 5;

    // Clears the byte-within-line offset so L2 only ever sees line addresses.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~((32'd1 << LINE_OFFSET_BITS) - 32'd1);
    endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Round-robin pick between the I-cache and D-cache request lines.
module arb_rr_select
    import cache_types_pkg::*;
(
    input  logic    req_i,
    input  logic    req_d,
    input  client_t last_grant,
    output client_t grant,
    output logic    valid
);

    // On a tie the client that was not served last wins, so neither can starve.
    always_comb begin
        valid = req_i | req_d;
        grant = CLIENT_I;
        if (req_i && req_d) begin
            grant = (last_grant == CLIENT_I) ? CLIENT_D : CLIENT_I;
        end else if (req_d) begin
            grant = CLIENT_D;
        end
    end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Merges I-cache and D-cache line traffic onto the single l2_cache port,
// one latched transaction at a time, and steers the L2 response back.
module l1_l2_arbiter
    import cache_types_pkg::*;
#(
    parameter int s_line       = 256,
    parameter bit DCACHE_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              icache_read,
    input  logic [31:0]       icache_address,
    output logic [s_line-1:0] icache_rdata,
    output logic              icache_resp,

    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [s_line-1:0] dcache_wdata,
    input  logic [31:0]       dcache_address,
    output logic [s_line-1:0] dcache_rdata,
    output logic              dcache_resp,

    output logic              l2_read,
    output logic              l2_write,
    output logic [s_line-1:0] l2_wdata,
    output logic [31:0]       l2_address,
    input  logic [s_line-1:0] l2_rdata,
    input  logic              l2_resp
);

    localparam client_t RESET_LAST_GRANT = DCACHE_FIRST ? CLIENT_I : CLIENT_D;

    arb_state_t        state;
    client_t           last_grant;
    client_t           grant_q;
    client_t           sel_grant;
    logic              sel_valid;
    logic              responding;
    logic [s_line-1:0] icache_rdata_q;
    logic [s_line-1:0] dcache_rdata_q;

    arb_rr_select u_select (
        .req_i      (icache_read),
        .req_d      (dcache_read | dcache_write),
        .last_grant (last_grant),
        .grant      (sel_grant),
        .valid      (sel_valid)
    );

    // A response only counts while a transaction is actually outstanding.
    assign responding  = (state == BUSY) && l2_resp && !rst;
    assign icache_resp = responding && (grant_q == CLIENT_I);
    assign dcache_resp = responding && (grant_q == CLIENT_D);

    assign icache_rdata = icache_resp ? l2_rdata : icache_rdata_q;
    assign dcache_rdata = dcache_resp ? l2_rdata : dcache_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_grant     <= RESET_LAST_GRANT;
            grant_q        <= CLIENT_I;
            l2_read        <= 1'b0;
            l2_write       <= 1'b0;
            l2_address     <= '0;
            l2_wdata       <= '0;
            icache_rdata_q <= '0;
            dcache_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        grant_q <= sel_grant;
                        state   <= BUSY;
                        if (sel_grant == CLIENT_D) begin
                            // A read+write collision is forwarded as a writeback.
                            l2_address <= line_align(dcache_address);
                            l2_wdata   <= dcache_wdata;
                            l2_write   <= dcache_write;
                            l2_read    <= ~dcache_write;
                        end else begin
                            l2_address <= line_align(icache_address);
                            l2_read    <= 1'b1;
                            l2_write   <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (l2_resp) begin
                        l2_read    <= 1'b0;
                        l2_write   <= 1'b0;
                        last_grant <= grant_q;
                        state      <= RECOVER;
                        if (grant_q == CLIENT_I) begin
                            icache_rdata_q <= l2_rdata;
                        end else begin
                            dcache_rdata_q <= l2_rdata;
                        end
                    end
                end
                RECOVER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_dcache_single_op: assert property (
        @(posedge clk) disable iff (rst) !(dcache_read && dcache_write)
    );

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Self-checking bench for l1_l2_arbiter: directed scenarios plus randomized
// two-client traffic checked against a round-robin reference model.
module tb_l1_l2_arbiter;

    localparam int CI = 0;
    localparam int CD = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         icache_read;
    logic [31:0]  icache_address;
    logic [255:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read;
    logic         dcache_write;
    logic [255:0] dcache_wdata;
    logic [31:0]  dcache_address;
    logic [255:0] dcache_rdata;
    logic         dcache_resp;
    logic         l2_read;
    logic         l2_write;
    logic [255:0] l2_wdata;
    logic [31:0]  l2_address;
    logic [255:0] l2_rdata;
    logic         l2_resp;

    int tests_run = 0;
    int tests_failed = 0;

    logic [255:0] last_rdata [2];
    int           last_served;

    always #5 clk = ~clk;

    l1_l2_arbiter #(.s_line(256), .DCACHE_FIRST(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_wdata   (dcache_wdata),
        .dcache_address (dcache_address),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .l2_read        (l2_read),
        .l2_write       (l2_write),
        .l2_wdata       (l2_wdata),
        .l2_address     (l2_address),
        .l2_rdata       (l2_rdata),
        .l2_resp        (l2_resp)
    );

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a - (a % 32);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        icache_read = 0; icache_address = 0;
        dcache_read = 0; dcache_write = 0; dcache_address = 0; dcache_wdata = 0;
        l2_resp = 0; l2_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        last_rdata[CI] = '0;
        last_rdata[CD] = '0;
        // Out of reset a tie goes to the D-cache, i.e. I counts as served last.
        last_served = CI;
    endtask

    task automatic drive_client(input int who, input bit active, input logic [31:0] addr,
                                input bit is_write, input logic [255:0] wdata);
        if (who == CI) begin
            icache_read    = active;
            icache_address = addr;
        end else begin
            dcache_read    = active & !is_write;
            dcache_write   = active & is_write;
            dcache_address = addr;
            dcache_wdata   = wdata;
        end
    endtask

    // Waits for the grant, checks the forwarded request, answers it and checks routing.
    task automatic serve(input int who, input logic [31:0] addr, input bit is_write,
                         input logic [255:0] wdata, input int exp_wait, input logic [255:0] rd);
        int   n;
        int   other;
        logic w_resp, o_resp;
        logic [255:0] w_rdata, o_rdata;
        n = 0;
        other = 1 - who;
        while (!(l2_read || l2_write) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (n != exp_wait) begin
            tests_failed++;
            $display("[TB] FAIL grant_latency: got %0d cycles, expected %0d", n, exp_wait);
        end
        tests_run++;
        if (l2_read !== !is_write || l2_write !== is_write) begin
            tests_failed++;
            $display("[TB] FAIL l2_op: read=%b write=%b, expected read=%b write=%b",
                     l2_read, l2_write, !is_write, is_write);
        end
        tests_run++;
        if (l2_address !== line_of(addr)) begin
            tests_failed++;
            $display("[TB] FAIL l2_address: got %h, expected %h", l2_address, line_of(addr));
        end
        if (is_write) begin
            tests_run++;
            if (l2_wdata !== wdata) begin
                tests_failed++;
                $display("[TB] FAIL l2_wdata: got %h, expected %h", l2_wdata, wdata);
            end
        end
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            tests_run++;
            if (l2_address !== line_of(addr) || (l2_read | l2_write) !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL busy_hold: addr=%h rd=%b wr=%b, expected addr=%h with request held",
                         l2_address, l2_read, l2_write, line_of(addr));
            end
        end
        l2_rdata = rd;
        l2_resp  = 1'b1;
        #1;
        w_resp  = (who == CI) ? icache_resp  : dcache_resp;
        o_resp  = (who == CI) ? dcache_resp  : icache_resp;
        w_rdata = (who == CI) ? icache_rdata : dcache_rdata;
        o_rdata = (who == CI) ? dcache_rdata : icache_rdata;
        tests_run++;
        if (w_resp !== 1'b1 || w_rdata !== rd) begin
            tests_failed++;
            $display("[TB] FAIL winner_resp: client %0d resp=%b rdata=%h, expected resp=1 rdata=%h",
                     who, w_resp, w_rdata, rd);
        end
        tests_run++;
        if (o_resp !== 1'b0 || o_rdata !== last_rdata[other]) begin
            tests_failed++;
            $display("[TB] FAIL other_resp: client %0d resp=%b rdata=%h, expected resp=0 rdata=%h",
                     other, o_resp, o_rdata, last_rdata[other]);
        end
        last_rdata[who] = rd;
        last_served = who;
        @(posedge clk); #1;
        l2_resp  = 1'b0;
        l2_rdata = rand_line();
        #1;
        tests_run++;
        if (l2_read !== 1'b0 || l2_write !== 1'b0 || icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL recover: rd=%b wr=%b iresp=%b dresp=%b, expected all 0",
                     l2_read, l2_write, icache_resp, dcache_resp);
        end
        tests_run++;
        if (icache_rdata !== last_rdata[CI] || dcache_rdata !== last_rdata[CD]) begin
            tests_failed++;
            $display("[TB] FAIL rdata_hold: i=%h d=%h, expected i=%h d=%h",
                     icache_rdata, dcache_rdata, last_rdata[CI], last_rdata[CD]);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (l2_read !== 1'b0 || l2_write !== 1'b0 || icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: rd=%b wr=%b iresp=%b dresp=%b, expected all 0",
                     l2_read, l2_write, icache_resp, dcache_resp);
        end
        tests_run++;
        if (l2_address !== 32'd0 || l2_wdata !== 256'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_l2_data: addr=%h wdata=%h, expected 0", l2_address, l2_wdata);
        end
        tests_run++;
        if (icache_rdata !== 256'd0 || dcache_rdata !== 256'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rdata: i=%h d=%h, expected 0", icache_rdata, dcache_rdata);
        end
    endtask

    task automatic test_icache_read();
        do_reset();
        drive_client(CI, 1'b1, 32'h0000_1234, 1'b0, '0);
        serve(CI, 32'h0000_1234, 1'b0, '0, 1, {8{32'hDEADBEEF}});
        tests_run++;
        if (line_of(32'h0000_1234) !== 32'h0000_1220) begin
            tests_failed++;
            $display("[TB] FAIL line_model: got %h, expected 00001220", line_of(32'h0000_1234));
        end
        drive_client(CI, 1'b0, '0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_alternation();
        logic [31:0] ia, da;
        int order [4] = '{CD, CI, CD, CI};
        do_reset();
        ia = $urandom(); da = $urandom();
        drive_client(CI, 1'b1, ia, 1'b0, '0);
        drive_client(CD, 1'b1, da, 1'b0, '0);
        for (int r = 0; r < 4; r++) begin
            serve(order[r], (order[r] == CI) ? ia : da, 1'b0, '0, (r == 0) ? 1 : 2, rand_line());
            if (order[r] == CI) begin
                ia = $urandom();
                drive_client(CI, 1'b1, ia, 1'b0, '0);
            end else begin
                da = $urandom();
                drive_client(CD, 1'b1, da, 1'b0, '0);
            end
        end
        drive_client(CI, 1'b0, '0, 1'b0, '0);
        drive_client(CD, 1'b0, '0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_write_hold();
        logic [255:0] pat;
        do_reset();
        pat = {8{32'hA5A5A5A5}};
        drive_client(CD, 1'b1, 32'h8000_0040, 1'b1, pat);
        @(posedge clk); #1;
        drive_client(CD, 1'b1, 32'h1234_5678, 1'b1, ~pat);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (l2_wdata !== pat || l2_write !== 1'b1 || l2_read !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL wdata_latched: wdata=%h wr=%b rd=%b, expected %h wr=1 rd=0",
                         l2_wdata, l2_write, l2_read, pat);
            end
        end
        serve(CD, 32'h8000_0040, 1'b1, pat, 0, rand_line());
        drive_client(CD, 1'b0, '0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        do_reset();
        drive_client(CI, 1'b1, 32'h0000_4000, 1'b0, '0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_client(CI, 1'b0, '0, 1'b0, '0);
        last_rdata[CI] = '0;
        last_rdata[CD] = '0;
        last_served = CI;
        tests_run++;
        if (l2_read !== 1'b0 || l2_write !== 1'b0 || icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: rd=%b wr=%b iresp=%b dresp=%b, expected all 0",
                     l2_read, l2_write, icache_resp, dcache_resp);
        end
        a = $urandom();
        drive_client(CI, 1'b1, a, 1'b0, '0);
        serve(CI, a, 1'b0, '0, 1, rand_line());
        drive_client(CI, 1'b0, '0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_spurious_resp();
        logic [31:0] a;
        do_reset();
        a = $urandom();
        drive_client(CI, 1'b1, a, 1'b0, '0);
        serve(CI, a, 1'b0, '0, 1, rand_line());
        drive_client(CI, 1'b0, '0, 1'b0, '0);
        @(posedge clk); #1;
        l2_rdata = rand_line();
        l2_resp  = 1'b1;
        #1;
        tests_run++;
        if (icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL spurious_resp: iresp=%b dresp=%b, expected 0 0", icache_resp, dcache_resp);
        end
        tests_run++;
        if (icache_rdata !== last_rdata[CI] || dcache_rdata !== last_rdata[CD]) begin
            tests_failed++;
            $display("[TB] FAIL spurious_rdata: i=%h d=%h, expected i=%h d=%h",
                     icache_rdata, dcache_rdata, last_rdata[CI], last_rdata[CD]);
        end
        @(posedge clk); #1;
        l2_resp = 1'b0;
        tests_run++;
        if (l2_read !== 1'b0 || l2_write !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL spurious_grant: rd=%b wr=%b, expected 0 0", l2_read, l2_write);
        end
    endtask

    task automatic test_drop_in_busy();
        logic [31:0] a;
        do_reset();
        a = $urandom();
        drive_client(CD, 1'b1, a, 1'b0, '0);
        @(posedge clk); #1;
        drive_client(CD, 1'b0, '0, 1'b0, '0);
        serve(CD, a, 1'b0, '0, 0, rand_line());
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_random_traffic();
        bit           pend [2];
        logic [31:0]  paddr [2];
        bit           pw [2];
        logic [255:0] pwd [2];
        int           who;
        int           exp_wait;
        int           c;
        do_reset();
        pend[CI] = 0; pend[CD] = 0;
        exp_wait = 1;
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k] = 1; paddr[k] = $urandom();
                    pw[k] = (k == CD) ? 1'($urandom_range(0, 1)) : 1'b0;
                    pwd[k] = rand_line();
                end
            end
            if (!pend[CI] && !pend[CD]) begin
                c = $urandom_range(0, 1);
                pend[c] = 1; paddr[c] = $urandom();
                pw[c] = (c == CD) ? 1'($urandom_range(0, 1)) : 1'b0;
                pwd[c] = rand_line();
            end
            drive_client(CI, pend[CI], paddr[CI], pw[CI], pwd[CI]);
            drive_client(CD, pend[CD], paddr[CD], pw[CD], pwd[CD]);
            if (pend[CI] && pend[CD]) who = 1 - last_served;
            else who = pend[CD] ? CD : CI;
            serve(who, paddr[who], pw[who], pwd[who], exp_wait, rand_line());
            pend[who] = 0;
            drive_client(who, 1'b0, '0, 1'b0, '0);
            exp_wait = 2;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_icache_read();
        test_alternation();
        test_write_hold();
        test_reset_mid();
        test_spurious_resp();
        test_drop_in_busy();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
